// File: rtl/bcd7seg_scan.sv
// Three-digit common-anode seven-segment scanner. Each frame latches a new shadow copy of the BCD digits.
// Optional build macro LEADING_ZERO_BLANK_EN turns off leading-zero digits.
module bcd7seg_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4,
  parameter int DP_DIGIT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       blank,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_GUARD = PW'(BLANK_CYCLES);

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    sh2, sh1, sh0;
  logic [3:0]    cur;
  logic          wrap;
  logic          suppress;
  logic          en;

  function automatic logic [6:0] decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign wrap = (pre == PRE_MAX);

  always_comb begin
    case (idx)
      2'd0:    cur = sh0;
      2'd1:    cur = sh1;
      default: cur = sh2;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A lit decimal point pins its own digit and every digit below it on.
  always_comb begin
    suppress = 1'b0;
    if (idx == 2'd2)
      suppress = (sh2 == 4'd0);
    else if (idx == 2'd1)
      suppress = (sh2 == 4'd0) && (sh1 == 4'd0);
    if (DP_DIGIT <= 2 && int'(idx) <= DP_DIGIT)
      suppress = 1'b0;
  end
`else
  assign suppress = 1'b0;
`endif

  assign en = (pre >= PRE_GUARD) && !blank && !suppress;

  // Scan state, frame capture and registered outputs (one cycle behind idx/pre)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= 2'd0;
      sh2 <= 4'd0;
      sh1 <= 4'd0;
      sh0 <= 4'd0;
      an  <= 3'b111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      pre <= wrap ? '0 : pre + PW'(1);
      if (wrap)
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (wrap && idx == 2'd2) begin
        sh2 <= d2;
        sh1 <= d1;
        sh0 <= d0;
      end
      an  <= en ? ~(3'b001 << idx) : 3'b111;
      seg <= decode(cur);
      dp  <= ~(en && int'(idx) == DP_DIGIT);
    end
  end

endmodule

// File: tb/tb_bcd7seg_scan.sv
// Bench for bcd7seg_scan: directed scenarios plus random digits and blanking, against a cycle-count reference model.
module tb_bcd7seg_scan;

  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk, rst;
  logic [3:0] d2, d1, d0;
  logic       blank;
  logic [2:0] an, an1;
  logic [6:0] seg, seg1;
  logic       dp, dp1;

  bcd7seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .DP_DIGIT(3)) dut (
    .clk(clk), .rst(rst), .d2(d2), .d1(d1), .d0(d0), .blank(blank),
    .an(an), .seg(seg), .dp(dp));

  bcd7seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .DP_DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .d2(d2), .d1(d1), .d0(d0), .blank(blank),
    .an(an1), .seg(seg1), .dp(dp1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Reference: position in the scan is just the number of edges since reset.
  int         cyc;
  int         msh [3];
  logic [2:0] e_an, e_an1;
  logic [6:0] e_seg;
  logic       e_dp, e_dp1;

  function automatic bit m_en(int c, logic blk, int dpd);
    int pre = c % RD;
    int idx = (c / RD) % 3;
    bit sup = 0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2 && msh[2] == 0) sup = 1;
    if (idx == 1 && msh[2] == 0 && msh[1] == 0) sup = 1;
    if (dpd <= 2 && idx <= dpd) sup = 0;
`endif
    return (pre >= BC) && !blk && !sup;
  endfunction

  function automatic logic [2:0] m_an(int c, logic blk, int dpd);
    int idx = (c / RD) % 3;
    return m_en(c, blk, dpd) ? ~(3'b001 << idx) : 3'b111;
  endfunction

  function automatic logic m_dp(int c, logic blk, int dpd);
    int idx = (c / RD) % 3;
    return !(m_en(c, blk, dpd) && idx == dpd);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc    <= 0;
      msh    <= '{0, 0, 0};
      e_an   <= 3'b111;
      e_an1  <= 3'b111;
      e_seg  <= 7'h7F;
      e_dp   <= 1'b1;
      e_dp1  <= 1'b1;
    end else begin
      e_an  <= m_an(cyc, blank, 3);
      e_an1 <= m_an(cyc, blank, 1);
      e_dp  <= m_dp(cyc, blank, 3);
      e_dp1 <= m_dp(cyc, blank, 1);
      e_seg <= seg_tab[msh[(cyc / RD) % 3]];
      if (cyc % (3 * RD) == 3 * RD - 1)
        msh <= '{int'(d0), int'(d1), int'(d2)};
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("an_dp1", 32'(an1), 32'(e_an1));
    chk("seg_dp1", 32'(seg1), 32'(e_seg));
    chk("dp_dp1", 32'(dp1), 32'(e_dp1));
    chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      n++;
      check_all();
    end
  endtask

  initial begin
    rst = 1'b1; blank = 1'b0;
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    step(3);
    chk("rst_an", 32'(an), 32'h7);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);

    rst = 1'b0;
    n = 0;
    step(5);
    chk("f0_an", 32'(an), 32'h6);
    chk("f0_seg", 32'(seg), 32'h40);
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    step(24);
    chk("f1_d0_an", 32'(an), 32'h6);
    chk("f1_d0_seg", 32'(seg), 32'h30);
    step(6);
    d0 = 4'd7;
    step(2);
    chk("f1_d1_an", 32'(an), 32'h5);
    chk("f1_d1_seg", 32'(seg), 32'h24);
    step(16);
    chk("f2_d0_an", 32'(an), 32'h6);
    chk("f2_d0_seg", 32'(seg), 32'h78);
    d0 = 4'hC;
    step(24);
    chk("dash_seg", 32'(seg), 32'h3F);
    step(8);
    chk("dp1_an", 32'(an1), 32'h5);
    chk("dp1_low", 32'(dp1), 32'h0);
    chk("dp3_high", 32'(dp), 32'h1);

    blank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("blank_an", 32'(an), 32'h7);
      chk("blank_an1", 32'(an1), 32'h7);
    end
    blank = 1'b0;
    step(3);
    chk("post_blank_an", 32'(an), 32'h5);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        d2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        d1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        d0 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      step(1);
    end
    blank = 1'b0;

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_an", 32'(an), 32'h7);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_dp", 32'(dp), 32'h1);
    step(2);
    rst = 1'b0;
    step(30);

    d2 = 4'd0; d1 = 4'd0; d0 = 4'd5;
    step(72);
    d2 = 4'd0; d1 = 4'd4; d0 = 4'd0;
    step(72);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
